// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control path and ALU control decoder.
// Build option MC_ADDI_EN adds the addi execute/writeback states.
package mips_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRd,
      StMemWb,
      StMemWr,
      StExec,
      StAluWb,
      StBranch,
      StJump
`ifdef MC_ADDI_EN
      ,
      StAddiEx,
      StAddiWb
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] ALUSRCB_RT    = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
interface multicycle_control_if;

   logic [5:0] opcode;
   logic       mem_ready;
   logic       pcwrite;
   logic       branch;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       memtoreg;
   logic       regdst;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [1:0] aluop;
   logic       illegal;

   modport master (
      input  opcode, mem_ready,
      output pcwrite, branch, iord, memwrite, irwrite, memtoreg, regdst, regwrite,
             alusrca, alusrcb, pcsrc, aluop, illegal
   );

   modport slave (
      output opcode, mem_ready,
      input  pcwrite, branch, iord, memwrite, irwrite, memtoreg, regdst, regwrite,
             alusrca, alusrcb, pcsrc, aluop, illegal
   );

endinterface

// File: rtl/mc_next_state.sv
// Combinational next-state logic for the multicycle control FSM; flags unsupported opcodes.
// Honours MC_ADDI_EN for the addi path.
module mc_next_state
   import mips_pkg::*;
(
   input  state_t     state_i,
   input  logic [5:0] opcode_i,
   input  logic       mem_ready_i,
   output state_t     state_d_o,
   output logic       illegal_o
);

   always_comb begin
      state_d_o = StFetch;
      illegal_o = 1'b0;
      case (state_i)
         StFetch:  state_d_o = mem_ready_i ? StDecode : StFetch;
         StDecode: begin
            case (opcode_i)
               OP_LW, OP_SW: state_d_o = StMemAdr;
               OP_RTYPE:     state_d_o = StExec;
               OP_BEQ:       state_d_o = StBranch;
               OP_J:         state_d_o = StJump;
`ifdef MC_ADDI_EN
               OP_ADDI:      state_d_o = StAddiEx;
`endif
               default:      illegal_o = 1'b1;
            endcase
         end
         StMemAdr: begin
            if (opcode_i == OP_LW) begin
               state_d_o = StMemRd;
            end else if (opcode_i == OP_SW) begin
               state_d_o = StMemWr;
            end
         end
         StMemRd:  state_d_o = mem_ready_i ? StMemWb : StMemRd;
         StMemWr:  state_d_o = mem_ready_i ? StFetch : StMemWr;
         StExec:   state_d_o = StAluWb;
`ifdef MC_ADDI_EN
         StAddiEx: state_d_o = StAddiWb;
`endif
         default:  state_d_o = StFetch;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: state register plus Moore output decode.
// Define MC_ADDI_EN to support addi.
module multicycle_control
   import mips_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   multicycle_control_if.master ctrl
);

   state_t state_q, state_d;
   logic   illegal;

   mc_next_state u_next_state (
      .state_i     (state_q),
      .opcode_i    (ctrl.opcode),
      .mem_ready_i (ctrl.mem_ready),
      .state_d_o   (state_d),
      .illegal_o   (illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      ctrl.pcwrite  = 1'b0;
      ctrl.branch   = 1'b0;
      ctrl.iord     = 1'b0;
      ctrl.memwrite = 1'b0;
      ctrl.irwrite  = 1'b0;
      ctrl.memtoreg = 1'b0;
      ctrl.regdst   = 1'b0;
      ctrl.regwrite = 1'b0;
      ctrl.alusrca  = 1'b0;
      ctrl.alusrcb  = ALUSRCB_RT;
      ctrl.pcsrc    = PCSRC_ALU;
      ctrl.aluop    = ALUOP_ADD;
      ctrl.illegal  = 1'b0;
      case (state_q)
         StFetch: begin
            ctrl.alusrcb = ALUSRCB_FOUR;
            ctrl.irwrite = ctrl.mem_ready;
            ctrl.pcwrite = ctrl.mem_ready;
         end
         StDecode: begin
            ctrl.alusrcb = ALUSRCB_IMMSH;
            ctrl.illegal = illegal;
         end
         StMemAdr: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_IMM;
         end
         StMemRd:  ctrl.iord = 1'b1;
         StMemWb: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         StMemWr: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         StExec: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_FUNC;
         end
         StAluWb: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         StBranch: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.branch  = 1'b1;
         end
         StJump: begin
            ctrl.pcsrc   = PCSRC_JUMP;
            ctrl.pcwrite = 1'b1;
         end
`ifdef MC_ADDI_EN
         StAddiEx: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_IMM;
         end
         StAddiWb: ctrl.regwrite = 1'b1;
`endif
         default: ;
      endcase
      // Reset suppresses every side-effecting strobe, whatever state the register holds.
      if (rst) begin
         ctrl.pcwrite  = 1'b0;
         ctrl.branch   = 1'b0;
         ctrl.memwrite = 1'b0;
         ctrl.irwrite  = 1'b0;
         ctrl.regwrite = 1'b0;
         ctrl.illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vectors against hand-derived values.
module tb_multicycle_control;

   // Vector layout: {pcwrite, branch, iord, memwrite, irwrite, memtoreg, regdst, regwrite,
   //                 alusrca, alusrcb[1:0], pcsrc[1:0], aluop[1:0], illegal}
   localparam logic [15:0] V_FETCH_R = {8'b1000_1000, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] V_FETCH_W = {8'b0000_0000, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] V_DECODE  = {8'b0000_0000, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] V_DEC_ILL = {8'b0000_0000, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1};
   localparam logic [15:0] V_MEMADR  = {8'b0000_0000, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] V_MEMRD   = {8'b0010_0000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] V_MEMWB   = {8'b0000_0101, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] V_MEMWR   = {8'b0011_0000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] V_EXEC    = {8'b0000_0000, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0};
   localparam logic [15:0] V_ALUWB   = {8'b0000_0011, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] V_ALUWB_R = {8'b0000_0010, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] V_BRANCH  = {8'b0100_0000, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
   localparam logic [15:0] V_JUMP    = {8'b1000_0000, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0};
   localparam logic [15:0] V_ADDIWB  = {8'b0000_0001, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] BAD  = 6'b111111;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   multicycle_control_if mc_if ();

   multicycle_control dut (
      .clk  (clk),
      .rst  (rst),
      .ctrl (mc_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's inputs in the low phase, then compare the settled outputs.
   task automatic step(input logic r, input logic mr, input logic [5:0] op, input string tag,
                       input logic [15:0] exp);
      logic [15:0] obs;
      @(negedge clk);
      rst             = r;
      mc_if.mem_ready = mr;
      mc_if.opcode    = op;
      #1;
      obs = {mc_if.pcwrite, mc_if.branch, mc_if.iord, mc_if.memwrite, mc_if.irwrite,
             mc_if.memtoreg, mc_if.regdst, mc_if.regwrite, mc_if.alusrca, mc_if.alusrcb,
             mc_if.pcsrc, mc_if.aluop, mc_if.illegal};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      total           = 0;
      bad             = 0;
      rst             = 1'b1;
      mc_if.mem_ready = 1'b1;
      mc_if.opcode    = LW;

      step(1'b1, 1'b1, LW, "reset_fetch", V_FETCH_W);

      step(1'b0, 1'b1, LW, "lw_fetch", V_FETCH_R);
      step(1'b0, 1'b1, LW, "lw_decode", V_DECODE);
      step(1'b0, 1'b1, LW, "lw_memadr", V_MEMADR);
      step(1'b0, 1'b1, LW, "lw_memrd", V_MEMRD);
      step(1'b0, 1'b1, LW, "lw_memwb", V_MEMWB);

      // Reset for two cycles from mid-instruction (ALUWB).
      step(1'b0, 1'b1, RT, "rt_fetch0", V_FETCH_R);
      step(1'b0, 1'b1, RT, "rt_decode0", V_DECODE);
      step(1'b0, 1'b1, RT, "rt_exec0", V_EXEC);
      step(1'b1, 1'b1, RT, "rst_in_aluwb", V_ALUWB_R);
      step(1'b1, 1'b1, RT, "rst_hold", V_FETCH_W);
      step(1'b0, 1'b1, RT, "rst_release", V_FETCH_R);

      step(1'b0, 1'b1, RT, "rt_decode", V_DECODE);
      step(1'b0, 1'b1, RT, "rt_exec", V_EXEC);
      step(1'b0, 1'b1, RT, "rt_aluwb", V_ALUWB);

      step(1'b0, 1'b1, SW, "sw_fetch", V_FETCH_R);
      step(1'b0, 1'b0, SW, "sw_decode_mr0", V_DECODE);
      step(1'b0, 1'b0, SW, "sw_memadr_mr0", V_MEMADR);
      step(1'b0, 1'b0, SW, "sw_memwr_w0", V_MEMWR);
      step(1'b0, 1'b0, SW, "sw_memwr_w1", V_MEMWR);
      step(1'b0, 1'b0, SW, "sw_memwr_w2", V_MEMWR);
      step(1'b0, 1'b1, SW, "sw_memwr_done", V_MEMWR);

      step(1'b0, 1'b0, BEQ, "fetch_stall", V_FETCH_W);
      step(1'b0, 1'b1, BEQ, "beq_fetch", V_FETCH_R);
      step(1'b0, 1'b1, BEQ, "beq_decode", V_DECODE);
      step(1'b0, 1'b1, BEQ, "beq_branch", V_BRANCH);

      step(1'b0, 1'b1, JMP, "j_fetch", V_FETCH_R);
      step(1'b0, 1'b0, JMP, "j_decode", V_DECODE);
      step(1'b0, 1'b0, JMP, "j_jump", V_JUMP);

      step(1'b0, 1'b1, BAD, "ill_fetch", V_FETCH_R);
      step(1'b0, 1'b1, BAD, "ill_decode", V_DEC_ILL);
      step(1'b0, 1'b1, BAD, "ill_back_fetch", V_FETCH_R);

      // Reset must also mask the illegal pulse.
      step(1'b0, 1'b1, BAD, "rst_ill_decode", V_DEC_ILL);
      step(1'b1, 1'b1, BAD, "rst_ill_fetch", V_FETCH_W);
      step(1'b0, 1'b1, BAD, "rst_ill_release", V_FETCH_R);
      step(1'b1, 1'b1, BAD, "rst_masks_ill", V_DECODE);
      step(1'b0, 1'b1, ADDI, "addi_fetch", V_FETCH_R);

`ifdef MC_ADDI_EN
      step(1'b0, 1'b1, ADDI, "addi_decode", V_DECODE);
      step(1'b0, 1'b1, ADDI, "addi_exec", V_MEMADR);
      step(1'b0, 1'b1, ADDI, "addi_wb", V_ADDIWB);
`else
      step(1'b0, 1'b1, ADDI, "addi_illegal", V_DEC_ILL);
`endif
      step(1'b0, 1'b1, LW, "lwr_fetch", V_FETCH_R);
      step(1'b0, 1'b1, LW, "lwr_decode", V_DECODE);
      step(1'b0, 1'b1, LW, "lwr_memadr", V_MEMADR);
      step(1'b0, 1'b0, LW, "lwr_memrd_wait", V_MEMRD);
      step(1'b1, 1'b0, LW, "lwr_memrd_rst", V_MEMRD);
      step(1'b0, 1'b0, LW, "lwr_after_rst", V_FETCH_W);
      step(1'b0, 1'b1, LW, "lwr_refetch", V_FETCH_R);
      step(1'b0, 1'b1, LW, "lwr_redecode", V_DECODE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
